// File: rtl/sha3_pkg.sv
// rtl/sha3_pkg.sv - shared SHA3 constants, lane addressing and digest FSM encoding
package sha3_pkg;

  localparam int LANE_W  = 64;
  localparam int STATE_W = 1600;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } fsm_state_t;

  // Bit offset of lane (x,y) inside the flattened 5x5 Keccak state.
  function automatic int lane_offset(input int x, input int y);
    return (x + 5 * y) * LANE_W;
  endfunction

endpackage

// File: rtl/digest_stream.sv
// rtl/digest_stream.sv - serialises the rate lanes of a final Keccak state into
// a ready/valid stream of LANE_W-bit digest beats, lane 0 first.
module digest_stream #(
  parameter int LANE_W    = sha3_pkg::LANE_W,
  parameter int N_LANES   = 8,
  parameter int BYTE_SWAP = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [sha3_pkg::STATE_W-1:0] inData,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic                         flush,
  output logic [LANE_W-1:0]            outData,
  output logic                         outValid,
  input  logic                         outReady,
  output logic                         outLast,
  output logic                         busy
);

  localparam int HOLD_W = N_LANES * LANE_W;
  localparam int CNT_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_LANES - 1);

  sha3_pkg::fsm_state_t state;
  logic [CNT_W-1:0]     cnt;
  logic [HOLD_W-1:0]    hold;
  logic [LANE_W-1:0]    lanes [N_LANES];
  logic [LANE_W-1:0]    cur_lane;

  assign inReady  = (state == sha3_pkg::IDLE);
  assign busy     = (state != sha3_pkg::IDLE);
  assign outValid = (state == sha3_pkg::SEND);
  assign outLast  = (state == sha3_pkg::SEND) && (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= sha3_pkg::IDLE;
      cnt   <= '0;
      hold  <= '0;
    end else if (flush) begin
      state <= sha3_pkg::IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        sha3_pkg::IDLE: begin
          if (inValid) begin
            hold  <= inData[HOLD_W-1:0];
            cnt   <= '0;
            state <= sha3_pkg::SEND;
          end
        end
        sha3_pkg::SEND: begin
          if (outReady) begin
            if (cnt == LAST_CNT) begin
              state <= sha3_pkg::IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= sha3_pkg::IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    assign lanes[k] = hold[k*LANE_W +: LANE_W];
  end

  assign cur_lane = lanes[cnt];

  if (BYTE_SWAP != 0) begin : g_swap
    for (genvar b = 0; b < LANE_W / 8; b++) begin : g_byte
      assign outData[8*b +: 8] = cur_lane[LANE_W-8-8*b +: 8];
    end
  end else begin : g_noswap
    assign outData = cur_lane;
  end

  // Capacity and the unused rate lanes never reach the output.
  if (HOLD_W < sha3_pkg::STATE_W) begin : g_unused
    logic unused_upper;
    assign unused_upper = ^inData[sha3_pkg::STATE_W-1:HOLD_W];
  end

endmodule

// File: tb/tb_digest_stream.sv
// tb/tb_digest_stream.sv - scoreboard bench for digest_stream with plain and
// byte-swapped instances driven by the same stimulus.
module tb_digest_stream;
  import sha3_pkg::*;

  localparam int LW = 64;
  localparam int NL = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1599:0] in_data;
  logic          in_valid;
  logic          flush;
  logic          out_ready;
  logic          in_ready, out_valid, out_last, busy_o;
  logic [LW-1:0] out_data;
  logic          in_ready_s, out_valid_s, out_last_s, busy_s;
  logic [LW-1:0] out_data_s;

  digest_stream #(.LANE_W(LW), .N_LANES(NL), .BYTE_SWAP(0)) dut (
    .clk(clk), .rst(rst), .inData(in_data), .inValid(in_valid), .inReady(in_ready),
    .flush(flush), .outData(out_data), .outValid(out_valid), .outReady(out_ready),
    .outLast(out_last), .busy(busy_o)
  );

  digest_stream #(.LANE_W(LW), .N_LANES(NL), .BYTE_SWAP(1)) dut_sw (
    .clk(clk), .rst(rst), .inData(in_data), .inValid(in_valid), .inReady(in_ready_s),
    .flush(flush), .outData(out_data_s), .outValid(out_valid_s), .outReady(out_ready),
    .outLast(out_last_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LW-1:0] data;
    logic [LW-1:0] sdata;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    beats_acc = 0;
  int    rdy_mode = 0;
  int    ph = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] lane_of(input logic [1599:0] st, input int k);
    return st[lane_offset(k % 5, k / 5) +: LW];
  endfunction

  task automatic push_expected(input logic [1599:0] st);
    beat_t b;
    for (int k = 0; k < NL; k++) begin
      b.data  = lane_of(st, k);
      b.sdata = {<<8{b.data}};
      b.last  = (k == NL - 1);
      exp_q.push_back(b);
    end
  endtask

  function automatic logic [1599:0] rand_state();
    logic [1599:0] st;
    for (int i = 0; i < 50; i++) st[32*i +: 32] = $urandom;
    return st;
  endfunction

  function automatic logic [1599:0] ramp_state();
    logic [1599:0] st;
    st = rand_state();
    for (int k = 0; k < NL; k++) st[lane_offset(k % 5, k / 5) +: LW] = 64'h0101_0101_0101_0101 * k;
    return st;
  endfunction

  // Downstream ready generator; changes only just after a rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = (ph % 3 == 0); ph++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: samples on the falling edge, pops on each beat that will be accepted.
  beat_t         e;
  logic          have_prev = 1'b0;
  logic [LW-1:0] prev_data, prev_sdata;
  logic          prev_last;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        have_prev = 1'b0;
        continue;
      end
      if (out_valid) begin
        check("swap_valid", out_valid_s, 1);
        if (have_prev) begin
          check("stall_data", out_data, prev_data);
          check("stall_sdata", out_data_s, prev_sdata);
          check("stall_last", out_last, prev_last);
        end
      end
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", out_data, e.data);
          check("beat_sdata", out_data_s, e.sdata);
          check("beat_last", out_last, e.last);
        end
        beats_acc++;
      end
      have_prev  = out_valid && !out_ready && !flush;
      prev_data  = out_data;
      prev_sdata = out_data_s;
      prev_last  = out_last;
    end
  end

  task automatic capture(input logic [1599:0] st);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    check("in_ready_wait", in_ready, 1);
    in_data  = st;
    in_valid = 1'b1;
    @(posedge clk);
    push_expected(st);
    #1;
    in_valid = 1'b0;
    check("cap_out_valid", out_valid, 1);
    check("cap_busy", busy_o, 1);
    check("cap_in_ready", in_ready, 0);
    check("cap_first_lane", out_data, lane_of(st, 0));
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o && n < 500) begin @(posedge clk); #1; n++; end
    check("idle_timeout", (n < 500), 1);
    check("idle_in_ready", in_ready, 1);
    check("idle_q_empty", exp_q.size(), 0);
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beats_acc < target && n < 200) begin @(posedge clk); #1; n++; end
    check("beat_wait", (beats_acc >= target), 1);
  endtask

  logic [1599:0] st, st2;
  int            cyc, base;

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_data = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy_o, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Ramp digest with continuous ready: 8 back-to-back beats.
    st = ramp_state();
    base = beats_acc;
    capture(st);
    wait_idle(cyc);
    check("ramp_cycles", cyc, 8);
    check("ramp_beats", beats_acc - base, 8);

    // Same digest with ready pattern 1,0,0.
    rdy_mode = 1; ph = 0;
    base = beats_acc;
    capture(st);
    wait_idle(cyc);
    check("stall_beats", beats_acc - base, 8);
    rdy_mode = 0;
    @(posedge clk); #1;

    // Byte-swapped first beat.
    st = rand_state();
    st[lane_offset(0, 0) +: LW] = 64'h0011223344556677;
    capture(st);
    check("swap_first", out_data_s, 64'h7766554433221100);
    wait_idle(cyc);

    // Flush after beat 3 is accepted.
    st = rand_state();
    beats_acc = 0;
    capture(st);
    wait_beats(4);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_busy", busy_o, 0);
    check("flush_in_ready", in_ready, 1);
    exp_q.delete();
    st = rand_state();
    capture(st);
    wait_idle(cyc);

    // Flush in IDLE blocks capture.
    flush = 1'b1; in_valid = 1'b1; in_data = rand_state();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("idle_flush_busy", busy_o, 0);
    check("idle_flush_valid", out_valid, 0);
    @(posedge clk); #1;

    // Asynchronous reset mid-digest.
    st = rand_state();
    beats_acc = 0;
    capture(st);
    wait_beats(3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_last", out_last, 0);
    check("arst_busy", busy_o, 0);
    check("arst_out_data", out_data, 0);
    check("arst_sdata", out_data_s, 0);
    check("arst_in_ready", in_ready, 1);
    exp_q.delete();
    @(negedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_quiet", out_valid, 0);
    end

    // New state offered mid-digest is ignored.
    rdy_mode = 2;
    st  = rand_state();
    st2 = rand_state();
    capture(st);
    @(posedge clk); #1;
    in_data = st2; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle(cyc);

    // Random digests with random backpressure.
    for (int t = 0; t < 6; t++) begin
      rdy_mode = $urandom_range(0, 2);
      capture(rand_state());
      wait_idle(cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/digest_stream.md
DIGEST_STREAM -- requirements
Module: digest_stream

Interface
REQ-001 SHALL have parameter LANE_W, default 64, meaning the width of one Keccak lane and of one output beat.
REQ-002 SHALL have parameter N_LANES, default 8, meaning the number of lanes emitted per digest (8 x 64 = 512 bits, SHA3-512).
REQ-003 SHALL have parameter BYTE_SWAP, default 0, meaning: when 1, bytes within each emitted lane are reversed.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port inData, input, 1600 bits: the final permuted state; lane (x,y) occupies bits [64*(x+5y)+63 : 64*(x+5y)].
REQ-008 SHALL have port inValid, input, 1 bit: inData holds a valid final state.
REQ-009 SHALL have port inReady, output, 1 bit: the block accepts a state this cycle.
REQ-010 SHALL have port flush, input, 1 bit: synchronous abort of the current digest.
REQ-011 SHALL have port outData, output, LANE_W bits: the current digest lane.
REQ-012 SHALL have port outValid, output, 1 bit: outData is valid.
REQ-013 SHALL have port outReady, input, 1 bit: the downstream consumer accepts the beat.
REQ-014 SHALL have port outLast, output, 1 bit: the current beat is lane N_LANES-1.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the block is not in IDLE.

Function
REQ-016 SHALL implement a two-state FSM with states IDLE and SEND.
REQ-017 SHALL drive inReady = (state==IDLE) combinationally, with no dependence on inValid.
REQ-018 SHALL, in IDLE, on a cycle where inValid && inReady: capture inData[N_LANES*LANE_W-1:0] into a holding register, clear the lane counter to 0, and enter SEND.
REQ-019 SHALL ignore inData[1599:N_LANES*LANE_W] (capacity and remaining rate lanes).
REQ-020 SHALL assert outValid in the cycle after capture (latency 1) and hold it throughout SEND.
REQ-021 SHALL drive outData from held lane[cnt], taken from bits [LANE_W*cnt+LANE_W-1 : LANE_W*cnt], byte-reversed when BYTE_SWAP=1; lane 0 is emitted first.
REQ-022 SHALL keep outData, outLast and cnt stable while outValid && !outReady.
REQ-023 SHALL, on outValid && outReady with cnt < N_LANES-1, increment cnt by 1.
REQ-024 SHALL assert outLast = (state==SEND) && (cnt==N_LANES-1).
REQ-025 SHALL, on outValid && outReady && outLast, return to IDLE, so that inReady rises in the next cycle; there is no back-to-back acceptance on the last beat.
REQ-026 SHALL make flush take priority over every handshake: SEND goes to IDLE, cnt is cleared to 0, and no further beats are emitted; flush in IDLE also blocks capture in that cycle.
REQ-027 SHALL size the lane counter as $clog2(N_LANES) bits, with no wrap-around beyond N_LANES-1.
REQ-028 SHALL ignore inValid while in SEND; the held state is never overwritten mid-digest.

Reset
REQ-029 SHALL, on rst high, immediately force state=IDLE, cnt=0 and the holding register to 0; consequently outValid=0, outLast=0, busy=0, inReady=1 and outData=0.
REQ-030 SHALL abandon a digest if reset occurs mid-SEND, and emit no beat until a new capture.

Structure
REQ-031 SHALL place the lane offset function (x+5y)*64, constants LANE_W=64 and STATE_W=1600, and the FSM state encoding in a shared sha3 package reused by the theta/rho/chi/iota stages.
REQ-032 SHALL be a single module; byte reversal SHALL be a generate loop, with no sub-module.

Verification
REQ-033 SHALL verify this scenario: lane k of the state = 64'h0101_0101_0101_0101*k with outReady held at 1 -> the capture cycle is followed by 8 consecutive beats k=0..7, with outLast only on the 8th beat and inReady high the cycle after.
REQ-034 SHALL verify this scenario: the same stimulus with outReady toggling 1,0,0,1,... -> each beat is held stable during stalls, exactly 8 accepted beats occur, and their values are unchanged.
REQ-035 SHALL verify this scenario: BYTE_SWAP=1 with lane 0 = 64'h0011223344556677 -> first beat = 64'h7766554433221100.
REQ-036 SHALL verify this scenario: flush asserted after beat 3 is accepted -> the next cycle has outValid=0, busy=0, inReady=1, and a following capture restarts at lane 0.
REQ-037 SHALL verify this scenario: rst asserted asynchronously mid-SEND (between clock edges) -> outValid, outLast and busy fall without waiting for a clock edge, and outData=0.
REQ-038 SHALL verify this scenario: inValid pulsed with a different state while in SEND -> it is ignored, and the emitted digest matches the first captured state.
